// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared widths, channel enum and position clamp for the servo PWM block
package servo_pkg;

    localparam int CNT_W = 12;
    localparam int POS_W = 10;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} chan_e;

    // Clamp is applied before the MIN_PULSE offset, so the result never exceeds pos_max.
    function automatic logic [CNT_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                   input logic [CNT_W-1:0] pos_max);
        logic [CNT_W-1:0] p;
        p = {{(CNT_W-POS_W){1'b0}}, pos};
        return (p > pos_max) ? pos_max : p;
    endfunction

endpackage

// File: rtl/servo_chan_slot.sv
// rtl/servo_chan_slot.sv - per-channel target/compare holder with slew-limited commit and PWM compare
module servo_chan_slot
    import servo_pkg::*;
#(
    parameter int MIN_PULSE = 1000,
    parameter int POS_MAX   = 1000,
    parameter int CENTER    = 1500,
    parameter int SLEW_STEP = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [POS_W-1:0] pos_i,
    input  logic             commit_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cntr_i,
    output logic             pending_o,
    output logic [CNT_W-1:0] cmp_o,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] PMAX_V   = CNT_W'(POS_MAX);
    localparam logic [CNT_W-1:0] CENTER_V = CNT_W'(CENTER);
    localparam logic [CNT_W-1:0] STEP_V   = CNT_W'(SLEW_STEP);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             up;
    logic [CNT_W-1:0] diff;

    // Direction picked first so the unsigned difference can never wrap.
    assign up   = target_q > cmp_q;
    assign diff = up ? (target_q - cmp_q) : (cmp_q - target_q);

    always_comb begin
        target_d  = target_q;
        cmp_d     = cmp_q;
        pending_d = pending_q;
        pwm_d     = enable_i && (cntr_i < cmp_q);
        if (commit_i) begin
            pending_d = 1'b0;
            if ((SLEW_STEP == 0) || (diff <= STEP_V)) begin
                cmp_d = target_q;
            end else if (up) begin
                cmp_d = cmp_q + STEP_V;
            end else begin
                cmp_d = cmp_q - STEP_V;
            end
        end
        // A load coinciding with a commit keeps pending so the new target lands next period.
        if (load_i) begin
            target_d  = MIN_V + clamp_pos(pos_i, PMAX_V);
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= CENTER_V;
            cmp_q     <= CENTER_V;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            target_q  <= target_d;
            cmp_q     <= cmp_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pending_o = pending_q;
    assign cmp_o     = cmp_q;
    assign pwm_o     = pwm_q;

endmodule

// File: rtl/servo_pwm_sched.sv
// rtl/servo_pwm_sched.sv - servo PWM timebase, period counter and sample handshake demux
module servo_pwm_sched
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1_000_000,
    parameter int PERIOD_TICKS = 3000,
    parameter int MIN_PULSE    = 1000,
    parameter int POS_MAX      = 1000,
    parameter int CENTER       = 1500,
    parameter int SLEW_STEP    = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_chan,
    input  logic [POS_W-1:0] s_pos,
    output logic [CNT_W-1:0] cntr_val,
    output logic             period_start,
    output logic [CNT_W-1:0] cmp_left,
    output logic [CNT_W-1:0] cmp_right,
    output logic             pwm_left,
    output logic             pwm_right
);

    localparam int                  DIV       = CLK_HZ / TICK_HZ;
    localparam int                  PRESC_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cntr_q, cntr_d;
    logic               tick;
    logic               wrap;
    logic               pend_left, pend_right;
    logic               accept;
    logic               load_left, load_right;

    assign tick = enable && (presc_q == PRESC_MAX);
    assign wrap = tick && (cntr_q == CNT_LAST);

    always_comb begin
        presc_d = presc_q;
        cntr_d  = cntr_q;
        if (!enable) begin
            presc_d = '0;
            cntr_d  = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (wrap) begin
                cntr_d = '0;
            end else if (tick) begin
                cntr_d = cntr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cntr_q  <= '0;
        end else begin
            presc_q <= presc_d;
            cntr_q  <= cntr_d;
        end
    end

    assign s_ready    = (chan_e'(s_chan) == CH_RIGHT) ? ~pend_right : ~pend_left;
    assign accept     = s_valid && s_ready;
    assign load_left  = accept && (chan_e'(s_chan) == CH_LEFT);
    assign load_right = accept && (chan_e'(s_chan) == CH_RIGHT);

    servo_chan_slot #(
        .MIN_PULSE (MIN_PULSE),
        .POS_MAX   (POS_MAX),
        .CENTER    (CENTER),
        .SLEW_STEP (SLEW_STEP)
    ) u_left (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_left),
        .pos_i     (s_pos),
        .commit_i  (wrap),
        .enable_i  (enable),
        .cntr_i    (cntr_q),
        .pending_o (pend_left),
        .cmp_o     (cmp_left),
        .pwm_o     (pwm_left)
    );

    servo_chan_slot #(
        .MIN_PULSE (MIN_PULSE),
        .POS_MAX   (POS_MAX),
        .CENTER    (CENTER),
        .SLEW_STEP (SLEW_STEP)
    ) u_right (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_right),
        .pos_i     (s_pos),
        .commit_i  (wrap),
        .enable_i  (enable),
        .cntr_i    (cntr_q),
        .pending_o (pend_right),
        .cmp_o     (cmp_right),
        .pwm_o     (pwm_right)
    );

    assign cntr_val     = cntr_q;
    assign period_start = wrap;

endmodule
